// File: rtl/cwc_capture_reader.sv
`default_nettype none
// ============================================================================
// Module  : cwc_capture_reader
// Brief   : Streams samples out of a capture RAM as bytes, MSB byte first.
//           Optional 4-byte header enabled by macro CWC_READER_HEADER_EN.
// Revision: 1.0 - initial release
// ============================================================================
module cwc_capture_reader #(
  parameter int DATA_WIDTH = 19,
  parameter int RAM_DEPTH  = 16384,
  parameter int ADDR_W     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       num_samples,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  localparam int BPS     = (DATA_WIDTH + 7) / 8;
  localparam int SHW     = BPS * 8;
  localparam int BIDX_W  = 8;

  localparam logic [BIDX_W-1:0] c_LAST_BIDX = BIDX_W'(BPS - 1);
  localparam logic [ADDR_W:0]   c_ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_TOP  = ADDR_W'(RAM_DEPTH - 1);

`ifdef CWC_READER_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_WAIT, S_SEND, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_FIN} state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [SHW-1:0]      sh_q, sh_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      sh_q     <= '0;
      bidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      sh_q     <= sh_d;
      bidx_q   <= bidx_d;
    end
  end

`ifdef CWC_READER_HEADER_EN
  logic [15:0] hdr_num;
  assign hdr_num = 16'(remain_q);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    sh_d      = sh_q;
    bidx_d    = bidx_q;
    ram_rd_en = 1'b0;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_data   = sh_q[SHW-1 -: 8];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = num_samples;
          bidx_d   = '0;
`ifdef CWC_READER_HEADER_EN
          state_d  = S_HDR;
`else
          state_d  = (num_samples == '0) ? S_FIN : S_FETCH;
`endif
        end
      end
`ifdef CWC_READER_HEADER_EN
      S_HDR: begin
        tx_valid = 1'b1;
        case (bidx_q[1:0])
          2'd0:    tx_data = 8'hCA;
          2'd1:    tx_data = 8'h57;
          2'd2:    tx_data = hdr_num[15:8];
          default: tx_data = hdr_num[7:0];
        endcase
        tx_last = (bidx_q == BIDX_W'(3)) && (remain_q == '0);
        if (tx_ready) begin
          if (bidx_q == BIDX_W'(3)) begin
            bidx_d  = '0;
            state_d = (remain_q == '0) ? S_FIN : S_FETCH;
          end else begin
            bidx_d  = bidx_q + 1'b1;
          end
        end
      end
`endif
      S_FETCH: begin
        ram_rd_en = 1'b1;
        addr_d    = (addr_q == c_ADDR_TOP) ? '0 : addr_q + 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        sh_d    = SHW'(ram_rd_data);
        bidx_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_last  = (bidx_q == c_LAST_BIDX) && (remain_q == c_ONE);
        // Shift only on handshake so data stays frozen under backpressure.
        if (tx_ready) begin
          sh_d = sh_q << 8;
          if (bidx_q == c_LAST_BIDX) begin
            remain_d = remain_q - c_ONE;
            state_d  = (remain_q == c_ONE) ? S_FIN : S_FETCH;
          end else begin
            bidx_d   = bidx_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_rd_addr = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_cwc_capture_reader.sv
`default_nettype none
// Directed self-checking bench for cwc_capture_reader with a 1-cycle-latency RAM model.
module tb_cwc_capture_reader;

  logic        clk = 1'b0;
  logic        rst, start, ram_rd_en, tx_valid, tx_ready, tx_last, busy, done;
  logic [13:0] start_addr, ram_rd_addr;
  logic [14:0] num_samples;
  logic [18:0] ram_rd_data;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  cwc_capture_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .num_samples(num_samples), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .done(done)
  );

  logic [18:0] ram [0:16383];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  int total = 0, bad = 0;
  logic [7:0]  bq[$], eq[$];
  logic        lq[$];
  logic [13:0] aq[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  int stall_err = 0, stall_seen = 0;
  logic p_stall = 1'b0, p_last = 1'b0;
  logic [7:0] p_data = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (rst) p_stall = 1'b0;
    else begin
      if (tx_valid && tx_ready) begin
        bq.push_back(tx_data); lq.push_back(tx_last); last_acc_cyc = cyc;
      end
      if (ram_rd_en) aq.push_back(ram_rd_addr);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (p_stall && !(tx_valid && tx_data == p_data && tx_last == p_last)) stall_err++;
      if (tx_valid && !tx_ready) begin
        stall_seen++;
        if (ram_rd_en) stall_err++;
      end
      p_stall = tx_valid && !tx_ready; p_data = tx_data; p_last = tx_last;
    end
  end

  logic       bp_en = 1'b0;
  logic [3:0] pat = 4'b1001;
  int         ph = 0;
  always @(negedge clk) begin
    if (bp_en) begin tx_ready = pat[ph]; ph = (ph + 1) % 4; end
    else tx_ready = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    bq.delete(); lq.delete(); aq.delete(); eq.delete();
    done_cnt = 0; stall_err = 0; stall_seen = 0;
  endtask

  task automatic exp_hdr(input int n);
    logic [15:0] t;
    t = 16'(n);
`ifdef CWC_READER_HEADER_EN
    eq.push_back(8'hCA); eq.push_back(8'h57); eq.push_back(t[15:8]); eq.push_back(t[7:0]);
`else
    if (t == 16'hFFFF) eq.push_back(8'h00);
`endif
  endtask

  task automatic exp_smp(input int v);
    logic [23:0] t;
    t = 24'(v);
    eq.push_back(t[23:16]); eq.push_back(t[15:8]); eq.push_back(t[7:0]);
  endtask

  task automatic pulse_start(input int sa, input int n);
    start = 1'b1; start_addr = 14'(sa); num_samples = 15'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 2000) begin @(negedge clk); k++; end
    tick(3);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_after"}, busy, 1'b0);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, " byte_count"}, bq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < bq.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), bq[i], eq[i]);
      chk($sformatf("%s last%0d", tag, i), lq[i], (i == eq.size() - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 19'(i);
    rst = 1'b1; start = 1'b1; start_addr = 14'd3; num_samples = 15'd1;
    tick(2);
    chk("rst rd_en", ram_rd_en, 1'b0);
    chk("rst rd_addr", ram_rd_addr, 14'd0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_last", tx_last, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    start = 1'b0; rst = 1'b0;
    tick(2);
    chk("idle busy", busy, 1'b0);

    // Basic readout with cycle-accurate latency.
    clr(); exp_hdr(2); exp_smp(5); exp_smp(6);
    pulse_start(5, 2);
    chk("t1 busy", busy, 1'b1);
`ifndef CWC_READER_HEADER_EN
    chk("t1 fetch rd_en", ram_rd_en, 1'b1);
    chk("t1 fetch addr", ram_rd_addr, 14'd5);
    tick(1);
    chk("t1 wait valid", tx_valid, 1'b0);
    tick(1);
    chk("t1 first valid", tx_valid, 1'b1);
    chk("t1 first data", tx_data, 8'h00);
`endif
    wait_done("t1");
    check_bytes("t1");
    chk("t1 done_lat", done_cyc, last_acc_cyc + 1);

    // Address wrap at the top of the RAM.
    clr(); exp_hdr(4); exp_smp(16382); exp_smp(16383); exp_smp(0); exp_smp(1);
    pulse_start(16382, 4);
    wait_done("t2");
    check_bytes("t2");
    chk("t2 nreads", aq.size(), 4);
    if (aq.size() == 4) begin
      chk("t2 addr0", aq[0], 14'd16382);
      chk("t2 addr1", aq[1], 14'd16383);
      chk("t2 addr2", aq[2], 14'd0);
      chk("t2 addr3", aq[3], 14'd1);
    end

    // Backpressure.
    clr(); exp_hdr(3); exp_smp(100); exp_smp(101); exp_smp(102);
    bp_en = 1'b1; tick(1);
    pulse_start(100, 3);
    wait_done("t3");
    bp_en = 1'b0; tick(1);
    check_bytes("t3");
    chk("t3 stall_violations", stall_err, 0);
    chk("t3 stalls_seen", (stall_seen > 0), 1'b1);

    // Empty readout.
    clr(); exp_hdr(0);
    pulse_start(9, 0);
    wait_done("t4");
    check_bytes("t4");
    chk("t4 nreads", aq.size(), 0);

    // Reset during SEND, then a fresh readout.
    clr();
    pulse_start(200, 3);
    for (int k = 0; k < 50 && !tx_valid; k++) tick(1);
    chk("t5 reached_send", tx_valid, 1'b1);
    tick(1);
    rst = 1'b1; tick(1);
    chk("t5 rst valid", tx_valid, 1'b0);
    chk("t5 rst busy", busy, 1'b0);
    rst = 1'b0; tick(1);
    clr(); exp_hdr(1); exp_smp(7);
    pulse_start(7, 1);
    wait_done("t5");
    check_bytes("t5");

    // Start while busy is ignored.
    clr(); exp_hdr(2); exp_smp(10); exp_smp(11);
    pulse_start(10, 2);
    tick(2);
    pulse_start(50, 1);
    wait_done("t6");
    check_bytes("t6");
    chk("t6 nreads", aq.size(), 2);
    if (aq.size() == 2) begin
      chk("t6 addr0", aq[0], 14'd10);
      chk("t6 addr1", aq[1], 14'd11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
